// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: merges non-stallable load results with
// handshaked ALU results, buffering ALU results that lose the port in a FIFO.
module writeback_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      exValid,
    output logic                      exReady,
    input  logic [REG_ADDR_WIDTH-1:0] exRdAddr,
    input  logic                      exWEnable,
    input  logic [DATA_WIDTH-1:0]     exData,
    input  logic                      memValid,
    input  logic [REG_ADDR_WIDTH-1:0] memRdAddr,
    input  logic [DATA_WIDTH-1:0]     memData,
    output logic                      wEnable,
    output logic [REG_ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0]     wData,
    output logic                      pending,
    output logic [COUNT_WIDTH-1:0]    writeCount
);

    localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

    logic [REG_ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] fifo_rd_d   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data_d [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]      count_q, count_d;
    logic                      wen_q, wen_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     wd_q, wd_d;
    logic [COUNT_WIDTH-1:0]    wcount_q, wcount_d;

    logic ex_accept, ex_write, mem_eff, fifo_empty;
    logic sel_pop, sel_byp, push;

    // Ready only from registered occupancy so upstream never sees a comb loop.
    assign exReady = rst & (count_q < CNT_WIDTH'(FIFO_DEPTH));

    assign wEnable    = wen_q;
    assign rdAddr     = rd_q;
    assign wData      = wd_q;
    assign pending    = (count_q != '0);
    assign writeCount = wcount_q;

    always_comb begin
        ex_accept  = exValid & exReady;
        ex_write   = ex_accept & exWEnable & (exRdAddr != '0);
        mem_eff    = memValid & (memRdAddr != '0);
        fifo_empty = (count_q == '0);

        // Priority: load, then FIFO head, then ALU bypass when nothing is queued.
        sel_pop = ~mem_eff & ~fifo_empty;
        sel_byp = ~mem_eff & fifo_empty & ex_write;
        push    = ex_write & ~sel_byp;

        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        wen_d       = 1'b0;
        rd_d        = rd_q;
        wd_d        = wd_q;
        wcount_d    = wcount_q;

        if (mem_eff) begin
            wen_d = 1'b1;
            rd_d  = memRdAddr;
            wd_d  = memData;
        end else if (sel_pop) begin
            wen_d = 1'b1;
            rd_d  = fifo_rd_q[rd_ptr_q];
            wd_d  = fifo_data_q[rd_ptr_q];
        end else if (sel_byp) begin
            wen_d = 1'b1;
            rd_d  = exRdAddr;
            wd_d  = exData;
        end

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = exRdAddr;
            fifo_data_d[wr_ptr_q] = exData;
            wr_ptr_d              = wr_ptr_q + PTR_WIDTH'(1);
        end
        if (sel_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end

        case ({push, sel_pop})
            2'b10:   count_d = count_q + CNT_WIDTH'(1);
            2'b01:   count_d = count_q - CNT_WIDTH'(1);
            default: count_d = count_q;
        endcase

        wcount_d = wcount_q + COUNT_WIDTH'(wen_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_rd_q   <= '{default: '0};
            fifo_data_q <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            wen_q       <= 1'b0;
            rd_q        <= '0;
            wd_q        <= '0;
            wcount_q    <= '0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            wen_q       <= wen_d;
            rd_q        <= rd_d;
            wd_q        <= wd_d;
            wcount_q    <= wcount_d;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed vector table, async reset
// and counter-wrap sequences, then random traffic against a queue-based model.
module tb_writeback_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          exValid, exReady, exWEnable;
    logic [AW-1:0] exRdAddr;
    logic [DW-1:0] exData;
    logic          memValid;
    logic [AW-1:0] memRdAddr;
    logic [DW-1:0] memData;
    logic          wEnable;
    logic [AW-1:0] rdAddr;
    logic [DW-1:0] wData;
    logic          pending;
    logic [CW-1:0] writeCount;

    int checks = 0;
    int errors = 0;

    writeback_arbiter #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .exValid(exValid), .exReady(exReady), .exRdAddr(exRdAddr),
        .exWEnable(exWEnable), .exData(exData),
        .memValid(memValid), .memRdAddr(memRdAddr), .memData(memData),
        .wEnable(wEnable), .rdAddr(rdAddr), .wData(wData),
        .pending(pending), .writeCount(writeCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ev, ewe;
        logic [AW-1:0] erd;
        logic [DW-1:0] ed;
        logic          mv;
        logic [AW-1:0] mrd;
        logic [DW-1:0] md;
        logic          rdy, wen;
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
        logic          pend;
        logic [CW-1:0] cnt;
    } vec_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    // Reference model state: pending ALU writes in acceptance order + output regs.
    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_wd;
    logic [CW-1:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ev, input logic ewe, input logic [AW-1:0] erd,
                         input logic [DW-1:0] ed, input logic mv, input logic [AW-1:0] mrd,
                         input logic [DW-1:0] md);
        exValid = ev; exWEnable = ewe; exRdAddr = erd; exData = ed;
        memValid = mv; memRdAddr = mrd; memData = md;
    endtask

    function automatic vec_t mk(logic ev, logic ewe, logic [AW-1:0] erd, logic [DW-1:0] ed,
                                logic mv, logic [AW-1:0] mrd, logic [DW-1:0] md,
                                logic rdy, logic wen, logic [AW-1:0] rd, logic [DW-1:0] wd,
                                logic pend, logic [CW-1:0] cnt);
        vec_t v;
        v.ev = ev; v.ewe = ewe; v.erd = erd; v.ed = ed;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.rdy = rdy; v.wen = wen; v.rd = rd; v.wd = wd; v.pend = pend; v.cnt = cnt;
        return v;
    endfunction

    // One cycle of the spec rules applied to the current inputs.
    task automatic model_step();
        bit   writing;
        ent_t e;
        writing = exValid && (mq.size() < DEPTH) && exWEnable && (exRdAddr != 0);
        e.rd = exRdAddr;
        e.d  = exData;
        m_we = 1'b1;
        if (memValid && memRdAddr != 0) begin
            m_rd = memRdAddr; m_wd = memData;
            if (writing) mq.push_back(e);
        end else if (mq.size() > 0) begin
            ent_t h;
            h = mq.pop_front();
            m_rd = h.rd; m_wd = h.d;
            if (writing) mq.push_back(e);
        end else if (writing) begin
            m_rd = e.rd; m_wd = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (m_we) m_cnt = m_cnt + CW'(1);
    endtask

    task automatic reset_pulse();
        drive(0, 0, '0, '0, 0, '0, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        m_we = 1'b0; m_rd = '0; m_wd = '0; m_cnt = '0;
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b0;
        drive(0, 0, '0, '0, 0, '0, '0);
        #1;
        check("rst_wEnable", 32'(wEnable), 0);
        check("rst_rdAddr", 32'(rdAddr), 0);
        check("rst_wData", wData, 0);
        check("rst_writeCount", 32'(writeCount), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_exReady", 32'(exReady), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        //          ev ewe erd ed      mv mrd md      rdy wen rd wd       pend cnt
        vecs.push_back(mk(1, 1, 3, 32'h11, 0, 0,  0,       1, 1, 3,  32'h11, 0, 1));
        vecs.push_back(mk(1, 1, 6, 32'hBB, 1, 5,  32'hAA,  1, 1, 5,  32'hAA, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0,  0,       1, 1, 6,  32'hBB, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0,  0,       1, 0, 6,  32'hBB, 0, 3));
        vecs.push_back(mk(1, 1, 7, 32'h70, 1, 10, 32'hA0,  1, 1, 10, 32'hA0, 1, 4));
        vecs.push_back(mk(1, 1, 8, 32'h80, 1, 11, 32'hA1,  1, 1, 11, 32'hA1, 1, 5));
        vecs.push_back(mk(1, 1, 9, 32'h90, 1, 12, 32'hA2,  0, 1, 12, 32'hA2, 1, 6));
        vecs.push_back(mk(1, 1, 9, 32'h90, 1, 13, 32'hA3,  0, 1, 13, 32'hA3, 1, 7));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0,  0,       0, 1, 7,  32'h70, 1, 8));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0,  0,       1, 1, 8,  32'h80, 0, 9));
        vecs.push_back(mk(1, 1, 9, 32'h90, 0, 0,  0,       1, 1, 9,  32'h90, 0, 10));
        vecs.push_back(mk(1, 1, 0, 32'h55, 0, 0,  0,       1, 0, 9,  32'h90, 0, 10));
        vecs.push_back(mk(1, 0, 4, 32'h66, 0, 0,  0,       1, 0, 9,  32'h90, 0, 10));
        vecs.push_back(mk(0, 1, 0, 32'h77, 1, 0,  32'h77,  1, 0, 9,  32'h90, 0, 10));
        vecs.push_back(mk(1, 1, 0, 32'h88, 1, 0,  32'h99,  1, 0, 9,  32'h90, 0, 10));

        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].ewe, vecs[i].erd, vecs[i].ed,
                  vecs[i].mv, vecs[i].mrd, vecs[i].md);
            check($sformatf("v%0d_exReady", i), 32'(exReady), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wEnable", i), 32'(wEnable), 32'(vecs[i].wen));
            check($sformatf("v%0d_rdAddr", i), 32'(rdAddr), 32'(vecs[i].rd));
            check($sformatf("v%0d_wData", i), wData, vecs[i].wd);
            check($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
            check($sformatf("v%0d_writeCount", i), 32'(writeCount), 32'(vecs[i].cnt));
        end

        // Fill the FIFO behind two loads, then reset asynchronously mid-cycle.
        drive(1, 1, 20, 32'hE0, 1, 10, 32'hC0);
        @(posedge clk); #1;
        drive(1, 1, 21, 32'hE1, 1, 11, 32'hC1);
        @(posedge clk); #1;
        check("fill_pending", 32'(pending), 1);
        check("fill_exReady", 32'(exReady), 0);
        check("fill_wEnable", 32'(wEnable), 1);
        drive(1, 1, 22, 32'hE2, 1, 15, 32'hCF);
        #3;
        rst = 1'b0;
        #1;
        check("arst_wEnable", 32'(wEnable), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_exReady", 32'(exReady), 0);
        check("arst_writeCount", 32'(writeCount), 0);
        @(posedge clk); #1;
        check("arst_hold_wEnable", 32'(wEnable), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst%0d_wEnable", i), 32'(wEnable), 0);
            check($sformatf("post_rst%0d_pending", i), 32'(pending), 0);
            check($sformatf("post_rst%0d_exReady", i), 32'(exReady), 1);
        end
        check("post_rst_writeCount", 32'(writeCount), 0);

        // 15 bypass writes reach all-ones; the 16th wraps the counter.
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, AW'(1 + i), DW'(i), 0, '0, '0);
            @(posedge clk); #1;
        end
        check("wrap_pre_count", 32'(writeCount), 15);
        drive(1, 1, 5'd30, 32'hDEAD, 0, '0, '0);
        @(posedge clk); #1;
        check("wrap_wEnable", 32'(wEnable), 1);
        check("wrap_rdAddr", 32'(rdAddr), 30);
        check("wrap_count", 32'(writeCount), 0);

        // Random traffic against the model.
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            logic [AW-1:0] erd, mrd;
            erd = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            mrd = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), erd,
                  DW'($urandom), 1'($urandom_range(0, 2) == 0), mrd, DW'($urandom));
            check("rnd_exReady", 32'(exReady), 32'(mq.size() < DEPTH));
            model_step();
            @(posedge clk); #1;
            check("rnd_wEnable", 32'(wEnable), 32'(m_we));
            check("rnd_rdAddr", 32'(rdAddr), 32'(m_rd));
            check("rnd_wData", wData, m_wd);
            check("rnd_pending", 32'(pending), 32'(mq.size() != 0));
            check("rnd_writeCount", 32'(writeCount), 32'(m_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
